dcache_dm_wt: RTL and testbench
===============================

Name: dcache_dm_wt

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache.
- Sits between the CPU load/store unit and the data-memory port, and is the successor to the bare tag/valid/data lookup array.
- Adds a request/response handshake, a read-miss refill FSM, write-through forwarding, single-cycle flush and saturating hit/miss counters.
- One word per line; synchronous-read arrays.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width. Byte offset = log2(DATA_WIDTH/8) bits.
- INDEX_WIDTH, 5, log2 number of lines (default 32 lines).
- COUNT_WIDTH, 16, width of the hit and miss counters.
- Derived: TAG_WIDTH = ADDRESS_WIDTH - INDEX_WIDTH - offset bits (default 25).

Ports:
- iCLK  in  1  clock, rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- iReq  in  1  CPU request valid.
- iWE  in  1  1 = store, 0 = load.
- iAddr  in  ADDRESS_WIDTH  byte address; offset bits ignored.
- iWData  in  DATA_WIDTH  store data.
- oReady  out  1  request accepted on the edge where iReq && oReady.
- oValid  out  1  one-cycle completion pulse.
- oRData  out  DATA_WIDTH  load data, valid when oValid && load.
- oHit  out  1  qualifies oValid: 1 = hit.
- iFlush  in  1  invalidate all lines.
- oMemReq  out  1  memory request, held until ack.
- oMemWE  out  1  memory write.
- oMemAddr  out  ADDRESS_WIDTH  word-aligned address.
- oMemWData  out  DATA_WIDTH  write data.
- iMemAck  in  1  memory done. For reads, iMemRData is valid in the same cycle.
- iMemRData  in  DATA_WIDTH  refill data.
- oHitCount  out  COUNT_WIDTH  saturating count of hits.
- oMissCount  out  COUNT_WIDTH  saturating count of misses.

Behaviour:
- Reset (async, iRST_N=0):
  - state=IDLE, all valid bits 0.
  - All outputs 0, including both counters.
  - Tag/data arrays are not reset.
  - Asserting reset mid-transaction drops oMemReq immediately; the pending request is lost.
- oReady = (state==IDLE) && !iFlush.
- IDLE:
  - iFlush=1: all valid bits cleared at the next edge; no request accepted; stay IDLE. Flush has priority over iReq.
  - iReq && oReady: latch iAddr/iWE/iWData; arrays read synchronously at iAddr index on the same edge; go LOOKUP.
- LOOKUP (1 cycle): hit = valid[idx] && tag[idx]==latched tag.
  - Load hit: oValid=1, oHit=1, oRData=array data in this cycle; hit counter +1; go IDLE. Load hit latency = 1 cycle after acceptance.
  - Load miss: miss counter +1; go REFILL.
  - Store, hit or miss: counter updated per hit/miss. On hit the data word is written at this edge and the tag is unchanged. On miss the array is untouched (no allocate). Go WRITE.
- REFILL:
  - oMemReq=1, oMemWE=0, oMemAddr=latched address with offset bits zeroed.
  - On the iMemAck edge: data[idx]=iMemRData, tag[idx]=latched tag, valid[idx]=1, capture iMemRData; go RESP.
- WRITE:
  - oMemReq=1, oMemWE=1, oMemWData=latched data, oMemAddr aligned.
  - On the iMemAck edge go RESP.
- RESP (1 cycle):
  - oValid=1; oHit = recorded lookup result.
  - Load: oRData = captured refill data.
  - Go IDLE.
- Outside response cycles:
  - oRData holds its last value.
  - oHit=0 whenever oValid=0.
- Memory interface:
  - oMemReq, oMemWE, oMemAddr and oMemWData are stable from request assertion until the ack edge.
  - oMemReq deasserts in the cycle after the ack.
  - iMemAck outside REFILL/WRITE is ignored.
- Throughput: at most one outstanding request. iReq during non-IDLE states is ignored, since oReady=0.
- Counters:
  - Increment only in LOOKUP, exactly one of the two per request.
  - Saturate at all-ones; no wrap.
- iFlush outside IDLE is ignored, not queued.
- Aliasing: two addresses with equal index and different tag evict each other on load refill.

Test Plan:
- Cold load 0x0000_0040, ack after 3 cycles with 0xDEADBEEF:
  - oMemReq high 3 cycles, oMemAddr=0x40.
  - oValid, oHit=0, oRData=0xDEADBEEF.
  - oMissCount=1.
- Repeat the load of 0x40: oValid exactly 1 cycle after acceptance, oHit=1, oRData=0xDEADBEEF, no oMemReq, oHitCount=1.
- Store 0x40 data 0x12345678 (hit):
  - oMemWE=1, oMemWData=0x12345678 until ack.
  - Subsequent load of 0x40 hits with 0x12345678.
- Store 0x0000_1000 (miss, index 0) then load 0x1000: the load misses (no allocate), refills and returns the memory value. A following load of 0x0 misses (evicted).
- iFlush and iReq asserted together in IDLE: oReady=0, request not accepted. The next load of 0x40 misses.
- Deassert iRST_N mid-REFILL:
  - oMemReq=0 immediately, counters=0.
  - After release, load 0x40 misses.
  - Also drive the hit counter to saturation (COUNT_WIDTH=4, 20 hits) -> holds at 15.

Source files
------------

// File: rtl/dcache_dm_wt.sv
// -----------------------------------------------------------------------------
// dcache_dm_wt
//
// Direct-mapped, write-through, no-write-allocate data cache with one word per
// line. It sits between the CPU load/store unit and the data-memory port.
//
// Tag and data arrays are read synchronously on the accept edge. The valid
// bits live in flops so that a flush can clear every line in one edge.
//
// Request flow:
//   IDLE   -> LOOKUP  request accepted (iReq && oReady)
//   LOOKUP -> IDLE    load hit, answered in the LOOKUP cycle itself
//   LOOKUP -> REFILL  load miss
//   LOOKUP -> WRITE   any store (the array is updated only on a hit)
//   REFILL/WRITE -> RESP  on iMemAck
//   RESP   -> IDLE
//
// Ports:
//   iCLK, iRST_N         clock (rising edge), asynchronous active-low reset
//   iReq, iWE            CPU request valid, 1 = store / 0 = load
//   iAddr, iWData        byte address (offset bits ignored), store data
//   oReady               request accepted on the edge where iReq && oReady
//   oValid, oHit         one-cycle completion pulse; oHit qualifies it
//   oRData               load data; holds its last value between responses
//   iFlush               invalidate all lines (IDLE only, beats iReq)
//   oMemReq, oMemWE      memory request (held until ack), write enable
//   oMemAddr, oMemWData  word-aligned address, write data
//   iMemAck, iMemRData   memory done; read data valid in the ack cycle
//   oHitCount            saturating hit counter
//   oMissCount           saturating miss counter
// -----------------------------------------------------------------------------
module dcache_dm_wt #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int INDEX_WIDTH   = 5,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic                     iReq,
  input  logic                     iWE,
  input  logic [ADDRESS_WIDTH-1:0] iAddr,
  input  logic [DATA_WIDTH-1:0]    iWData,
  output logic                     oReady,
  output logic                     oValid,
  output logic [DATA_WIDTH-1:0]    oRData,
  output logic                     oHit,
  input  logic                     iFlush,
  output logic                     oMemReq,
  output logic                     oMemWE,
  output logic [ADDRESS_WIDTH-1:0] oMemAddr,
  output logic [DATA_WIDTH-1:0]    oMemWData,
  input  logic                     iMemAck,
  input  logic [DATA_WIDTH-1:0]    iMemRData,
  output logic [COUNT_WIDTH-1:0]   oHitCount,
  output logic [COUNT_WIDTH-1:0]   oMissCount
);

  localparam int OFFSET_WIDTH = $clog2(DATA_WIDTH / 8);
  localparam int LINE_WIDTH   = ADDRESS_WIDTH - OFFSET_WIDTH;
  localparam int TAG_WIDTH    = LINE_WIDTH - INDEX_WIDTH;
  localparam int LINES        = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_REFILL = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Storage arrays (never reset; validity is carried by valid_q)
  logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];
  logic [LINES-1:0]      valid_q;

  // Request latched on the accept edge
  logic [LINE_WIDTH-1:0] line_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic                  we_p0;

  // Synchronous array read, visible during LOOKUP
  logic [TAG_WIDTH-1:0]  tag_rd_p1;
  logic [DATA_WIDTH-1:0] data_rd_p1;
  logic                  hit_p1;

  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [COUNT_WIDTH-1:0] hit_cnt_q;
  logic [COUNT_WIDTH-1:0] miss_cnt_q;

  logic                     ready;
  logic                     accept;
  logic                     lookup_hit;
  logic                     refill_done;
  logic [INDEX_WIDTH-1:0]   idx_in;
  logic [INDEX_WIDTH-1:0]   idx_p0;
  logic [TAG_WIDTH-1:0]     tag_p0;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     unused_offset;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    logic [COUNT_WIDTH-1:0] one;
    one = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  // Byte-offset bits select nothing in a one-word line.
  assign unused_offset = ^iAddr[OFFSET_WIDTH-1:0];

  // Held low during reset so the handshake stays quiet until release.
  assign ready  = iRST_N && (state_q == ST_IDLE) && !iFlush;
  assign accept = iReq && ready;

  assign idx_in   = iAddr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign idx_p0   = line_p0[INDEX_WIDTH-1:0];
  assign tag_p0   = line_p0[LINE_WIDTH-1 -: TAG_WIDTH];
  assign mem_addr = {line_p0, {OFFSET_WIDTH{1'b0}}};

  // valid_q can be read directly: nothing alters it between accept and LOOKUP.
  assign lookup_hit  = valid_q[idx_p0] && (tag_rd_p1 == tag_p0);
  assign refill_done = (state_q == ST_REFILL) && iMemAck;

  // ---- stage p0/p1: request latch, array read and array update ----
  always_ff @(posedge iCLK) begin
    if (accept) begin
      line_p0    <= iAddr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
      wdata_p0   <= iWData;
      tag_rd_p1  <= tag_mem[idx_in];
      data_rd_p1 <= data_mem[idx_in];
    end
    // Store hit updates the word in place; store miss leaves the line alone.
    if ((state_q == ST_LOOKUP) && we_p0 && lookup_hit) begin
      data_mem[idx_p0] <= wdata_p0;
    end
    if (refill_done) begin
      data_mem[idx_p0] <= iMemRData;
      tag_mem[idx_p0]  <= tag_p0;
    end
  end

  // ---- control state, valid bits, response data and counters ----
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      we_p0      <= 1'b0;
      hit_p1     <= 1'b0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_p0 <= iWE;
      end
      if ((state_q == ST_IDLE) && iFlush) begin
        valid_q <= '0;
      end else if (refill_done) begin
        valid_q[idx_p0] <= 1'b1;
      end
      if (state_q == ST_LOOKUP) begin
        hit_p1 <= lookup_hit;
        if (lookup_hit) begin
          hit_cnt_q <= sat_inc(hit_cnt_q);
        end else begin
          miss_cnt_q <= sat_inc(miss_cnt_q);
        end
        if (!we_p0 && lookup_hit) begin
          rdata_q <= data_rd_p1;
        end
      end
      if (refill_done) begin
        rdata_q <= iMemRData;
      end
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (we_p0)           state_d = ST_WRITE;
        else if (lookup_hit) state_d = ST_IDLE;
        else                 state_d = ST_REFILL;
      end
      ST_REFILL: begin
        if (iMemAck) state_d = ST_RESP;
      end
      ST_WRITE: begin
        if (iMemAck) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---- outputs ----
  always_comb begin
    oReady    = ready;
    oValid    = 1'b0;
    oHit      = 1'b0;
    oRData    = rdata_q;
    oMemReq   = 1'b0;
    oMemWE    = 1'b0;
    oMemAddr  = '0;
    oMemWData = '0;
    case (state_q)
      ST_LOOKUP: begin
        // Load hit answers straight from the array read.
        if (!we_p0 && lookup_hit) begin
          oValid = 1'b1;
          oHit   = 1'b1;
          oRData = data_rd_p1;
        end
      end
      ST_REFILL: begin
        oMemReq  = 1'b1;
        oMemAddr = mem_addr;
      end
      ST_WRITE: begin
        oMemReq   = 1'b1;
        oMemWE    = 1'b1;
        oMemAddr  = mem_addr;
        oMemWData = wdata_p0;
      end
      ST_RESP: begin
        oValid = 1'b1;
        oHit   = hit_p1;
      end
      default: begin
      end
    endcase
  end

  assign oHitCount  = hit_cnt_q;
  assign oMissCount = miss_cnt_q;

endmodule

// File: tb/tb_dcache_dm_wt.sv
module tb_dcache_dm_wt;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic          iReq = 1'b0;
  logic          iWE = 1'b0;
  logic [AW-1:0] iAddr = '0;
  logic [DW-1:0] iWData = '0;
  logic          iFlush = 1'b0;
  logic          iMemAck = 1'b0;
  logic [DW-1:0] iMemRData = '0;
  logic          oReady, oValid, oHit, oMemReq, oMemWE;
  logic [DW-1:0] oRData, oMemWData;
  logic [AW-1:0] oMemAddr;
  logic [CW-1:0] oHitCount, oMissCount;

  always #5 iCLK = ~iCLK;

  dcache_dm_wt #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .COUNT_WIDTH(CW)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iReq(iReq), .iWE(iWE), .iAddr(iAddr),
    .iWData(iWData), .oReady(oReady), .oValid(oValid), .oRData(oRData),
    .oHit(oHit), .iFlush(iFlush), .oMemReq(oMemReq), .oMemWE(oMemWE),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .iMemAck(iMemAck),
    .iMemRData(iMemRData), .oHitCount(oHitCount), .oMissCount(oMissCount)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit we; bit hit; logic [31:0] rdata; int lat; int acc; } resp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; int delay; } memx_t;

  resp_t rq[$];
  memx_t mq[$];

  bit          mv [32];
  logic [24:0] mt [32];
  logic [31:0] md [32];
  logic [31:0] mem [logic [29:0]];
  int m_hits = 0;
  int m_misses = 0;

  function automatic logic [31:0] mem_rd(input logic [29:0] w);
    if (mem.exists(w)) return mem[w];
    return {w[15:0], ~w[15:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
    rq.delete();
    mq.delete();
  endtask

  task automatic model_flush();
    for (int i = 0; i < 32; i++) mv[i] = 1'b0;
  endtask

  task automatic model_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay);
    int          idx;
    logic [24:0] tag;
    logic [29:0] w;
    bit          hit;
    resp_t       r;
    memx_t       m;
    idx = int'(addr[6:2]);
    tag = addr[31:7];
    w   = addr[31:2];
    hit = mv[idx] && (mt[idx] == tag);
    if (hit) m_hits = (m_hits < CMAX) ? m_hits + 1 : CMAX;
    else     m_misses = (m_misses < CMAX) ? m_misses + 1 : CMAX;
    r.we = we; r.hit = hit; r.acc = cyc; r.rdata = '0; r.lat = delay + 2;
    m.we = we; m.addr = {w, 2'b00}; m.wdata = we ? wdata : 32'h0; m.delay = delay;
    if (!we) begin
      if (hit) begin
        r.rdata = md[idx];
        r.lat = 1;
      end else begin
        r.rdata = mem_rd(w);
        mv[idx] = 1'b1; mt[idx] = tag; md[idx] = r.rdata;
        mq.push_back(m);
      end
    end else begin
      if (hit) md[idx] = wdata;
      mem[w] = wdata;
      mq.push_back(m);
    end
    rq.push_back(r);
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    bit    busy;
    int    cnt;
    memx_t cur;
    busy = 1'b0;
    cnt = 0;
    forever begin
      @(negedge iCLK);
      iMemAck = 1'b0;
      if (!iRST_N || !oMemReq) begin
        busy = 1'b0;
        // Stray acks while nothing is outstanding must be ignored.
        iMemAck = ($urandom_range(0, 7) == 0);
        iMemRData = $urandom;
      end else begin
        if (!busy) begin
          if (mq.size() == 0) begin
            check("unexpected_memreq", 96'(oMemReq), 96'(0));
            cur.we = oMemWE; cur.addr = oMemAddr; cur.wdata = oMemWData; cur.delay = 1;
          end else begin
            cur = mq.pop_front();
            check("mem_addr", 96'(oMemAddr), 96'(cur.addr));
            check("mem_we", 96'(oMemWE), 96'(cur.we));
            if (cur.we) check("mem_wdata", 96'(oMemWData), 96'(cur.wdata));
          end
          busy = 1'b1;
          cnt = 0;
        end else begin
          check("mem_stable", {31'h0, oMemWE, oMemAddr, (cur.we ? oMemWData : 32'h0)},
                {31'h0, cur.we, cur.addr, cur.wdata});
        end
        cnt++;
        if (cnt >= cur.delay) begin
          iMemAck = 1'b1;
          iMemRData = cur.we ? $urandom : mem_rd(cur.addr[31:2]);
          busy = 1'b0;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : monitor
    resp_t r;
    forever begin
      @(negedge iCLK);
      if (iRST_N && oValid) begin
        if (rq.size() == 0) begin
          check("unexpected_valid", 96'(oValid), 96'(0));
        end else begin
          r = rq.pop_front();
          check("resp_hit", 96'(oHit), 96'(r.hit));
          if (!r.we) check("resp_rdata", 96'(oRData), 96'(r.rdata));
          check("resp_latency", 96'(cyc - r.acc), 96'(r.lat));
        end
      end else if (iRST_N) begin
        check("hit_without_valid", 96'(oHit), 96'(0));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int delay);
    int waited;
    waited = 0;
    @(negedge iCLK);
    while (!oReady && waited < 100) begin
      @(negedge iCLK);
      waited++;
    end
    if (!oReady) begin
      check("ready_timeout", 96'(oReady), 96'(1));
      return;
    end
    iReq = 1'b1; iWE = we; iAddr = addr; iWData = wdata;
    model_req(we, addr, wdata, delay);
    @(posedge iCLK);
    #1;
    iReq = 1'b0; iWE = 1'($urandom); iAddr = $urandom; iWData = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge iCLK);
      if (rq.size() == 0) break;
    end
    check("drain", 96'(rq.size()), 96'(0));
    @(negedge iCLK);
    check("hit_count", 96'(oHitCount), 96'(m_hits));
    check("miss_count", 96'(oMissCount), 96'(m_misses));
  endtask

  task automatic do_flush(input bit with_req);
    @(negedge iCLK);
    iFlush = 1'b1; iReq = with_req; iWE = 1'b0; iAddr = 32'h40;
    #1;
    check("ready_during_flush", 96'(oReady), 96'(0));
    model_flush();
    @(posedge iCLK);
    #1;
    iFlush = 1'b0; iReq = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRST_N = 1'b0;
    model_reset();
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a;
    bit          we;
    model_reset();
    // Reset state
    repeat (2) @(negedge iCLK);
    check("reset_ctrl", 96'({oReady, oValid, oHit, oMemReq, oMemWE}), 96'(0));
    check("reset_rdata", 96'(oRData), 96'(0));
    check("reset_mem", 96'({oMemAddr, oMemWData}), 96'(0));
    check("reset_counts", 96'({oHitCount, oMissCount}), 96'(0));
    @(negedge iCLK);
    iRST_N = 1'b1;

    // Cold load, then repeat hit
    mem[30'h10] = 32'hDEADBEEF;
    issue(1'b0, 32'h40, 32'h0, 3); wait_done();
    issue(1'b0, 32'h40, 32'h0, 3); wait_done();

    // Store hit then load it back
    issue(1'b1, 32'h40, 32'h12345678, 2); wait_done();
    issue(1'b0, 32'h40, 32'h0, 2); wait_done();

    // Store miss does not allocate; then aliasing eviction
    mem[30'h400] = 32'hCAFEF00D;
    issue(1'b1, 32'h1000, 32'hA5A5A5A5, 2); wait_done();
    issue(1'b0, 32'h1000, 32'h0, 1); wait_done();
    issue(1'b0, 32'h0, 32'h0, 2); wait_done();

    // Flush beats a simultaneous request
    issue(1'b0, 32'h40, 32'h0, 1); wait_done();
    do_flush(1'b1);
    repeat (3) @(negedge iCLK);
    issue(1'b0, 32'h40, 32'h0, 2); wait_done();

    // Reset in the middle of a refill
    do_flush(1'b0);
    issue(1'b0, 32'h40, 32'h0, 10);
    repeat (4) @(negedge iCLK);
    check("in_refill", 96'(oMemReq), 96'(1));
    #2;
    iRST_N = 1'b0;
    model_reset();
    #1;
    check("rst_memreq", 96'(oMemReq), 96'(0));
    check("rst_counts", 96'({oHitCount, oMissCount, oValid}), 96'(0));
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    issue(1'b0, 32'h40, 32'h0, 2); wait_done();

    // Hit counter saturation
    for (int i = 0; i < 20; i++) begin
      issue(1'b0, 32'h40, 32'h0, 1); wait_done();
    end
    check("hit_saturated", 96'(oHitCount), 96'(CMAX));

    // Randomised traffic over a few aliasing lines
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) do_flush(1'($urandom_range(0, 1)));
      a = 32'(($urandom_range(0, 2) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      we = ($urandom_range(0, 9) < 4);
      issue(we, a, $urandom, $urandom_range(1, 4));
      wait_done();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
